jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Shares a bank of NBITS JK flip-flops between NREQ requesters. Each requester issues SET / RESET / TOGGLE / HOLD commands on one bit of the bank through a valid/ready handshake. A round-robin arbiter grants one command at a time, and a small FSM drives that bit's J/K pair for a programmable number of cycles. The block sits between control logic and the JK storage bank, and is the only writer of the bank.

## Interface
- NREQ, 4, number of requesters (≥2)
- NBITS, 8, flip-flops in the bank
- IW, 3, index width, ≥ clog2(NBITS)
- CW, 4, repeat-count width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_op  in  2*NREQ  op per requester, slice [2i+1:2i]
- req_idx  in  IW*NREQ  target bit per requester
- req_cnt  in  CW*NREQ  repeat count per requester
- q  out  NBITS  bank state
- busy  out  1  high in EXEC
- grant_id  out  clog2(NREQ)  requester owning the current command
- done  out  1  one-cycle pulse in the last EXEC cycle
- err  out  1  one-cycle pulse with done when the index is out of range

## Operation
- Op encoding:
  - 00 HOLD: J=0, K=0.
  - 01 RESET: J=0, K=1.
  - 10 SET: J=1, K=0.
  - 11 TOGGLE: J=1, K=1.
- Cell behaviour: J==K==1 toggles, J==K==0 holds, otherwise q←J.
- FSM states: IDLE, EXEC.
- IDLE:
  - If any req_valid is high, the arbiter picks winner w by round-robin, starting at (last_grant+1) mod NREQ.
  - req_ready[w]=1 combinationally in the same cycle; the handshake completes.
  - At the clock edge, the block latches op, idx, cnt and grant_id, and moves to EXEC.
  - If no req_valid is high, it stays in IDLE.
- EXEC:
  - The latched J/K pair is applied to bit idx.
  - All other bits get J=K=0.
  - Remaining count decrements each cycle.
  - On the last cycle, done=1 and the next state is IDLE.
- Count rule: cnt=0 is treated as 1, so the effective count is max(cnt,1).
- HOLD still occupies the bank for the effective count cycles (delay slot).
- Out-of-range idx (≥NBITS): the command is accepted and executes as HOLD for the effective count; err pulses together with done.
- req_ready is 0 for every requester while in EXEC; commands are never preempted.
- The round-robin pointer updates only on a handshake.
- Requesters may change op, idx and cnt only after the handshake; a valid request must stay asserted until it is accepted.

## Timing
- Reset values (rst_n low, asynchronous):
  - q=0, state=IDLE, pointer such that requester 0 has highest priority.
  - req_ready=0, busy=0, done=0, err=0, grant_id=0.
- Latency: handshake in cycle c0; J/K driven during c1..cN, where N = effective count.
  - q changes at the end of each of c1..cN, visible from c2.
  - done is high in cN; busy is high c1..cN.
- Throughput: one IDLE bubble between commands; the next handshake is possible at c(N+1) at the earliest.
- Simultaneous valids: exactly one requester is granted; a requester is never granted twice in a row while another is waiting.
- Reset mid-EXEC: the command is dropped, all state returns to reset values, and no done pulse is issued.
- q is registered; req_ready and grant decode are combinational from req_valid and the pointer.

## Structure
- Package jk_ctrl_pkg holds:
  - OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE constants.
  - State enum (ST_IDLE, ST_EXEC).
  - Helper function op_to_jk returning {J,K}.
- Sub-module jk_cell: one JK flip-flop with asynchronous active-low clear to 0, instantiated NBITS times in a generate loop.
- The round-robin arbiter stays inline in jk_bank_arbiter.

## Test plan
- Reset, then a single request: req0 SET idx=2 cnt=0 → ready in c0; q=0x04 from c2; done in c1; busy only in c1.
- TOGGLE repeat: req1 TOGGLE idx=0 cnt=3 from q=0 → q bit0 reads 1, 0, 1 in c2, c3, c4; done in c3; next ready possible in c4.
- Round-robin with all 4 requesters valid continuously, HOLD cnt=1 → grant order 0, 1, 2, 3, 0; each requester receives ready exactly once per rotation.
- Out-of-range index: SET idx=9 with NBITS=8 → q unchanged; err and done both high in c1.
- Reset mid-operation: TOGGLE idx=5 cnt=10, rst_n dropped in c4 → q=0 immediately, busy=0, no done pulse; a new request is accepted right after rst_n rises.
- RESET after SET: SET idx=7, then RESET idx=7 → q bit7 reads 1, then 0; all other bits remain 0 throughout.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - op encodings, FSM states and J/K decode for the JK bank arbiter
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  function automatic logic [1:0] op_to_jk(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_RESET:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-low clear
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b11:   q <= ~q;
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbitration of SET/RESET/TOGGLE/HOLD commands onto a JK bank
module jk_bank_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IW    = 3,
  parameter int CW    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [IW*NREQ-1:0]        req_idx,
  input  logic [CW*NREQ-1:0]        req_cnt,
  output logic [NBITS-1:0]          q,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      done,
  output logic                      err
);

  localparam int GW = $clog2(NREQ);

  state_t          state;
  logic [GW-1:0]   last;
  logic [1:0]      op_r;
  logic [IW-1:0]   idx_r;
  logic            oob_r;
  logic [CW-1:0]   rem;

  logic            any_v;
  logic [GW-1:0]   win;
  logic [1:0]      op_w;
  logic [IW-1:0]   idx_w;
  logic [CW-1:0]   cnt_w;
  logic [CW-1:0]   eff_w;
  logic            oob_w;
  logic [NBITS-1:0] j_v;
  logic [NBITS-1:0] k_v;

  // Search starts one past the last winner so nobody is granted twice while another waits.
  always_comb begin
    int cand;
    cand  = 0;
    any_v = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!any_v && req_valid[cand]) begin
        any_v = 1'b1;
        win   = GW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && any_v) req_ready[win] = 1'b1;
    op_w  = req_op[2*int'(win) +: 2];
    idx_w = req_idx[IW*int'(win) +: IW];
    cnt_w = req_cnt[CW*int'(win) +: CW];
    eff_w = (cnt_w == '0) ? CW'(1) : cnt_w;
    oob_w = 1'b1;
    for (int i = 0; i < NBITS; i++) begin
      if (idx_w == IW'(i)) oob_w = 1'b0;
    end
  end

  // Only the addressed bit sees the latched J/K; an out-of-range index degrades to HOLD.
  always_comb begin
    logic [1:0] jk;
    jk  = op_to_jk(op_r);
    j_v = '0;
    k_v = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (state == ST_EXEC && !oob_r && idx_r == IW'(i)) begin
        j_v[i] = jk[1];
        k_v[i] = jk[0];
      end
    end
  end

  for (genvar g = 0; g < NBITS; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_v[g]),
      .k     (k_v[g]),
      .q     (q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= GW'(NREQ - 1);
      op_r     <= OP_HOLD;
      idx_r    <= '0;
      oob_r    <= 1'b0;
      rem      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_v) begin
            state    <= ST_EXEC;
            last     <= win;
            grant_id <= win;
            op_r     <= op_w;
            idx_r    <= idx_w;
            oob_r    <= oob_w;
            rem      <= eff_w;
            busy     <= 1'b1;
            done     <= (eff_w == CW'(1));
            err      <= (eff_w == CW'(1)) && oob_w;
          end
        end
        ST_EXEC: begin
          if (rem == CW'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
          end else begin
            rem  <= rem - CW'(1);
            done <= (rem == CW'(2));
            err  <= (rem == CW'(2)) && oob_r;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - directed self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IW    = 4;
  localparam int CW    = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [2*NREQ-1:0]       req_op;
  logic [IW*NREQ-1:0]      req_idx;
  logic [CW*NREQ-1:0]      req_cnt;
  logic [NBITS-1:0]        q;
  logic                    busy;
  logic [1:0]              grant_id;
  logic                    done;
  logic                    err;

  int n_checks = 0;
  int n_errors = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_idx   (req_idx),
    .req_cnt   (req_cnt),
    .q         (q),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [IW-1:0] idx,
                         input logic [CW-1:0] cnt);
    req_valid[i]         = 1'b1;
    req_op[2*i +: 2]     = op;
    req_idx[IW*i +: IW]  = idx;
    req_cnt[CW*i +: CW]  = cnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_idx = '0; req_cnt = '0;
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // req0 SET idx=2 cnt=0
    set_req(0, 2'b10, 4'd2, 4'd0);
    #1;
    check("t1_ready_c0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0; #1;
    check("t1_busy_c1", 32'(busy), 32'h1);
    check("t1_done_c1", 32'(done), 32'h1);
    check("t1_q_c1", 32'(q), 32'h0);
    cyc();
    check("t1_q_c2", 32'(q), 32'h04);
    check("t1_busy_c2", 32'(busy), 32'h0);
    check("t1_done_c2", 32'(done), 32'h0);

    // req1 TOGGLE idx=0 cnt=3
    set_req(1, 2'b11, 4'd0, 4'd3);
    #1;
    check("t2_ready_c0", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0; #1;
    check("t2_gid_c1", 32'(grant_id), 32'h1);
    check("t2_done_c1", 32'(done), 32'h0);
    cyc();
    check("t2_q_c2", 32'(q), 32'h05);
    check("t2_done_c2", 32'(done), 32'h0);
    cyc();
    check("t2_q_c3", 32'(q), 32'h04);
    check("t2_done_c3", 32'(done), 32'h1);
    cyc();
    check("t2_q_c4", 32'(q), 32'h05);
    check("t2_busy_c4", 32'(busy), 32'h0);
    set_req(3, 2'b00, 4'd0, 4'd1);
    #1;
    check("t2_ready_c4", 32'(req_ready), 32'h8);
    req_valid = '0;
    #1;

    // Round robin, all four valid with HOLD cnt=1
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 4'd1, 4'd1);
    for (int g = 0; g < 5; g++) begin
      #1;
      check($sformatf("rr_ready_%0d", g), 32'(req_ready), 32'(1 << (g % NREQ)));
      cyc();
      check($sformatf("rr_gid_%0d", g), 32'(grant_id), 32'(g % NREQ));
      check($sformatf("rr_busyready_%0d", g), {31'(req_ready), busy}, 32'h1);
      cyc();
    end
    req_valid = '0;
    check("rr_q", 32'(q), 32'h0);
    cyc();

    // Out-of-range index
    set_req(2, 2'b10, 4'd9, 4'd0);
    #1;
    check("oob_ready_c0", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0; #1;
    check("oob_done_c1", 32'(done), 32'h1);
    check("oob_err_c1", 32'(err), 32'h1);
    cyc();
    check("oob_q_c2", 32'(q), 32'h0);
    check("oob_err_c2", 32'(err), 32'h0);

    // Reset mid-operation: TOGGLE idx=5 cnt=10
    set_req(0, 2'b11, 4'd5, 4'd10);
    #1;
    check("mid_ready_c0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    cyc(); cyc(); cyc();
    check("mid_q_c4", 32'(q), 32'h20);
    check("mid_busy_c4", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_q_rst", 32'(q), 32'h0);
    check("mid_busy_rst", 32'(busy), 32'h0);
    check("mid_done_rst", 32'(done), 32'h0);
    cyc();
    rst_n = 1'b1;
    // RESET after SET on bit 7, issued immediately after reset release
    set_req(1, 2'b10, 4'd7, 4'd1);
    #1;
    check("rs_ready_set", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0; #1;
    check("rs_done_set", 32'(done), 32'h1);
    cyc();
    check("rs_q_set", 32'(q), 32'h80);
    check("rs_done_idle", 32'(done), 32'h0);
    set_req(3, 2'b01, 4'd7, 4'd2);
    #1;
    check("rs_ready_rst", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0; #1;
    check("rs_q_c1", 32'(q), 32'h80);
    check("rs_done_c1", 32'(done), 32'h0);
    cyc();
    check("rs_q_c2", 32'(q), 32'h00);
    check("rs_done_c2", 32'(done), 32'h1);
    cyc();
    check("rs_q_c3", 32'(q), 32'h00);
    check("rs_busy_c3", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
